// File: rtl/stopwatch_display.sv
// stopwatch_display
// Consumer of the master clock divider outputs. Turns the divided clock levels
// into one-cycle events, runs an MM:SS stopwatch with pause, clear and adjust
// modes, and drives a 4-digit multiplexed active-low 7-segment display.
//
// Ports:
//   clk            system clock, the only clock
//   rst_n          synchronous active-low reset
//   clock1Hz_in    1 Hz level, rising edge = one count event
//   clock2Hz_in    2 Hz level, rising edge = one adjust event
//   clockFast_in   fast level, rising edge = one digit-scan advance
//   clockBlink_in  blink level, used as a level
//   btn_pause      one-cycle pulse, toggles run/pause
//   btn_reset      one-cycle pulse, clears time to 00:00
//   adj            level, 1 = adjust mode
//   sel            level, adjust target (0 = minutes, 1 = seconds)
//   seg[6:0]       active-low segments, seg[6]=g .. seg[0]=a
//   an[3:0]        active-low digit enables, an[0]=secO .. an[3]=minT
//
// Optional build macro LEADING_ZERO_BLANK_EN: blanks the minutes-tens digit
// while it is zero.
//
// state   | meaning
// PAUSED  | time held, 1 Hz events ignored
// RUN     | each 1 Hz event adds one second
// ADJUST  | 2 Hz events step the selected field; r_ret_state holds the mode
//         | to return to when adj drops

module stopwatch_display #(
    parameter int MAX_MIN = 59,
    parameter int SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clock1Hz_in,
    input  logic       clock2Hz_in,
    input  logic       clockFast_in,
    input  logic       clockBlink_in,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       adj,
    input  logic       sel,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam logic [1:0] ST_PAUSED = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_ADJUST = 2'd2;

    localparam logic [3:0] MIN_T_MAX = 4'(MAX_MIN / 10);
    localparam logic [3:0] MIN_O_MAX = 4'(MAX_MIN % 10);
    localparam logic [3:0] SEC_T_MAX = 4'(SEC_MAX / 10);
    localparam logic [3:0] SEC_O_MAX = 4'(SEC_MAX % 10);

    // BCD field increment: full wrap at {t_max,o_max}, else ripple ones into tens.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                           input logic [3:0] t_max, input logic [3:0] o_max);
        if (t == t_max && o == o_max) begin
            bcd_inc = 8'h00;
        end else if (o == 4'd9) begin
            bcd_inc = {t + 4'd1, 4'd0};
        end else begin
            bcd_inc = {t, o + 4'd1};
        end
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [2:0] w_in;
    logic [2:0] r_in;
    logic [2:0] r_in_q;
    logic [2:0] w_ev;
    logic       r_adj_q;
    logic       w_adj_rise;

    logic [1:0] r_state;
    logic [1:0] r_ret_state;
    logic [1:0] w_state_nx;
    logic [1:0] w_ret_nx;
    logic [1:0] w_cur;
    logic [1:0] w_toggled;

    logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o;
    logic [3:0] w_min_t_nx, w_min_o_nx, w_sec_t_nx, w_sec_o_nx;
    logic [7:0] w_sec_inc;
    logic [7:0] w_min_inc;

    logic [1:0] r_idx;
    logic [1:0] w_idx_nx;
    logic [3:0] w_digit;
    logic [3:0] w_an_nx;
    logic       w_blank;

    // w_ev[0] = 1 Hz count, w_ev[1] = 2 Hz adjust, w_ev[2] = scan advance
    assign w_in       = {clockFast_in, clock2Hz_in, clock1Hz_in};
    assign w_ev       = r_in & ~r_in_q;
    assign w_adj_rise = adj & ~r_adj_q;

    // Mode FSM. Any state code other than RUN/ADJUST is treated as PAUSED.
    always_comb begin
        w_state_nx = r_state;
        w_ret_nx   = r_ret_state;
        w_cur      = (r_state == ST_RUN) ? ST_RUN : ST_PAUSED;
        w_toggled  = ST_PAUSED;
        if (r_state == ST_ADJUST) begin
            w_toggled = (r_ret_state == ST_RUN) ? ST_PAUSED : ST_RUN;
            w_ret_nx  = btn_pause ? w_toggled : r_ret_state;
            if (!adj) begin
                w_state_nx = w_ret_nx;
            end
        end else begin
            w_toggled = (w_cur == ST_RUN) ? ST_PAUSED : ST_RUN;
            if (w_adj_rise) begin
                w_state_nx = ST_ADJUST;
                // a pause press in the entry cycle is folded into the saved mode
                w_ret_nx   = btn_pause ? w_toggled : w_cur;
            end else begin
                w_state_nx = btn_pause ? w_toggled : w_cur;
            end
        end
    end

    // Time update; btn_reset overrides any increment in the same cycle.
    always_comb begin
        w_min_t_nx = r_min_t;
        w_min_o_nx = r_min_o;
        w_sec_t_nx = r_sec_t;
        w_sec_o_nx = r_sec_o;
        w_sec_inc  = bcd_inc(r_sec_t, r_sec_o, SEC_T_MAX, SEC_O_MAX);
        w_min_inc  = bcd_inc(r_min_t, r_min_o, MIN_T_MAX, MIN_O_MAX);
        if (btn_reset) begin
            w_min_t_nx = 4'd0;
            w_min_o_nx = 4'd0;
            w_sec_t_nx = 4'd0;
            w_sec_o_nx = 4'd0;
        end else if (r_state == ST_RUN && w_ev[0]) begin
            {w_sec_t_nx, w_sec_o_nx} = w_sec_inc;
            if (r_sec_t == SEC_T_MAX && r_sec_o == SEC_O_MAX) begin
                {w_min_t_nx, w_min_o_nx} = w_min_inc;
            end
        end else if (r_state == ST_ADJUST && w_ev[1]) begin
            if (sel) begin
                {w_sec_t_nx, w_sec_o_nx} = w_sec_inc;
            end else begin
                {w_min_t_nx, w_min_o_nx} = w_min_inc;
            end
        end
    end

    // Display decode works on next-cycle values so the index, time and
    // an/seg all change on the same edge.
    always_comb begin
        w_idx_nx = w_ev[2] ? r_idx + 2'd1 : r_idx;
        case (w_idx_nx)
            2'd0:    w_digit = w_sec_o_nx;
            2'd1:    w_digit = w_sec_t_nx;
            2'd2:    w_digit = w_min_o_nx;
            default: w_digit = w_min_t_nx;
        endcase
        w_blank = (w_state_nx == ST_ADJUST) && clockBlink_in &&
                  (sel ? (w_idx_nx < 2'd2) : (w_idx_nx >= 2'd2));
`ifdef LEADING_ZERO_BLANK_EN
        if (w_idx_nx == 2'd3 && w_min_t_nx == 4'd0) begin
            w_blank = 1'b1;
        end
`endif
        w_an_nx = w_blank ? 4'b1111 : ~(4'b0001 << w_idx_nx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // edge history seeded from the live inputs so reset creates no event
            r_in        <= w_in;
            r_in_q      <= w_in;
            r_adj_q     <= adj;
            r_state     <= ST_PAUSED;
            r_ret_state <= ST_PAUSED;
            r_min_t     <= 4'd0;
            r_min_o     <= 4'd0;
            r_sec_t     <= 4'd0;
            r_sec_o     <= 4'd0;
            r_idx       <= 2'd0;
            an          <= 4'b1110;
            seg         <= 7'b1000000;
        end else begin
            r_in        <= w_in;
            r_in_q      <= r_in;
            r_adj_q     <= adj;
            r_state     <= w_state_nx;
            r_ret_state <= w_ret_nx;
            r_min_t     <= w_min_t_nx;
            r_min_o     <= w_min_o_nx;
            r_sec_t     <= w_sec_t_nx;
            r_sec_o     <= w_sec_o_nx;
            r_idx       <= w_idx_nx;
            an          <= w_an_nx;
            seg         <= seg_decode(w_digit);
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display
// Directed bench for stopwatch_display. Runs a default instance (MAX_MIN=59)
// and a MAX_MIN=9 instance on shared stimulus; time is observed through the
// scanned display outputs.

module tb_stopwatch_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clock1Hz_in, clock2Hz_in, clockFast_in, clockBlink_in;
    logic       btn_pause, btn_reset, adj, sel;
    logic [6:0] seg, seg9;
    logic [3:0] an, an9;

    int n_tests = 0;
    int n_fail  = 0;
    int idx     = 0;

    logic [6:0] seg_tab [10];

    always #5 clk = ~clk;

    stopwatch_display dut (
        .clk(clk), .rst_n(rst_n),
        .clock1Hz_in(clock1Hz_in), .clock2Hz_in(clock2Hz_in),
        .clockFast_in(clockFast_in), .clockBlink_in(clockBlink_in),
        .btn_pause(btn_pause), .btn_reset(btn_reset), .adj(adj), .sel(sel),
        .seg(seg), .an(an)
    );

    stopwatch_display #(.MAX_MIN(9)) dut9 (
        .clk(clk), .rst_n(rst_n),
        .clock1Hz_in(clock1Hz_in), .clock2Hz_in(clock2Hz_in),
        .clockFast_in(clockFast_in), .clockBlink_in(clockBlink_in),
        .btn_pause(btn_pause), .btn_reset(btn_reset), .adj(adj), .sel(sel),
        .seg(seg9), .an(an9)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_an(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: an observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic chk_seg(input string tag, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: seg observed %b expected %b", tag, act, exp);
        end
    endtask

    // which: 0 = 1 Hz, 1 = 2 Hz, 2 = fast
    task automatic pulse(input int which);
        case (which)
            0: clock1Hz_in = 1'b1;
            1: clock2Hz_in = 1'b1;
            default: clockFast_in = 1'b1;
        endcase
        cyc(2);
        clock1Hz_in  = 1'b0;
        clock2Hz_in  = 1'b0;
        clockFast_in = 1'b0;
        cyc(2);
        if (which == 2) idx = (idx + 1) % 4;
    endtask

    task automatic pulses(input int which, input int n);
        for (int k = 0; k < n; k++) pulse(which);
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        cyc(1);
        btn_pause = 1'b0;
        cyc(1);
    endtask

    // 1 Hz rising edge whose event cycle coincides with a button pulse
    task automatic ev1_with(input bit do_pause, input bit do_reset);
        clock1Hz_in = 1'b1;
        cyc(1);
        btn_pause = do_pause;
        btn_reset = do_reset;
        cyc(1);
        btn_pause   = 1'b0;
        btn_reset   = 1'b0;
        clock1Hz_in = 1'b0;
        cyc(2);
    endtask

    // Scans all four digits and checks an/seg of one instance against mm:ss.
    task automatic check_disp(input string tag, input int which, input int mm,
                              input int ss, input bit blink_on);
        int         d;
        logic [3:0] exp_an;
        for (int k = 0; k < 4; k++) begin
            pulse(2);
            case (idx)
                0: d = ss % 10;
                1: d = ss / 10;
                2: d = mm % 10;
                default: d = mm / 10;
            endcase
            exp_an = ~(4'b0001 << idx);
            if (blink_on && (sel ? (idx < 2) : (idx >= 2))) exp_an = 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 3 && (mm / 10) == 0) exp_an = 4'b1111;
`endif
            if (which == 0) begin
                chk_an(tag, an, exp_an);
                chk_seg(tag, seg, seg_tab[d]);
            end else begin
                chk_an(tag, an9, exp_an);
                chk_seg(tag, seg9, seg_tab[d]);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        idx   = 0;
        cyc(1);
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        rst_n = 1'b0;
        clock1Hz_in = 0; clock2Hz_in = 0; clockFast_in = 0; clockBlink_in = 0;
        btn_pause = 0; btn_reset = 0; adj = 0; sel = 0;
        cyc(1);
        do_reset();
        chk_an("reset_an", an, 4'b1110);
        chk_seg("reset_seg", seg, 7'b1000000);
        chk_an("reset_an9", an9, 4'b1110);

        // paused: 1 Hz events do not count
        pulses(0, 3);
        check_disp("paused_scan", 0, 0, 0, 0);

        // run 61 seconds
        press_pause();
        pulses(0, 61);
        check_disp("run_0101", 0, 1, 1, 0);

        // clear keeps RUN
        btn_reset = 1'b1; cyc(1); btn_reset = 1'b0; cyc(1);
        check_disp("clear", 0, 0, 0, 0);
        pulse(0);
        check_disp("run_after_clear", 0, 0, 1, 0);

        // preload 59:58 (09:58 on the MAX_MIN=9 instance) via adjust
        press_pause();
        adj = 1'b1; sel = 1'b0; cyc(1);
        pulses(1, 59);
        sel = 1'b1;
        pulses(1, 57);
        check_disp("adj_5958", 0, 59, 58, 0);
        check_disp("adj9_0958", 1, 9, 58, 0);
        adj = 1'b0; cyc(1);
        pulse(0);
        check_disp("paused_after_adj", 0, 59, 58, 0);
        press_pause();
        pulse(0);
        check_disp("run_5959", 0, 59, 59, 0);
        check_disp("run9_0959", 1, 9, 59, 0);
        pulse(0);
        check_disp("full_wrap", 0, 0, 0, 0);
        check_disp("full_wrap9", 1, 0, 0, 0);

        // seconds adjust with wrap, no carry into minutes; 1 Hz ignored
        adj = 1'b1; sel = 1'b1; cyc(1);
        pulses(1, 58);
        pulse(0);
        check_disp("adj_0058", 0, 0, 58, 0);
        pulses(1, 3);
        check_disp("adj_sec_wrap", 0, 0, 1, 0);
        clockBlink_in = 1'b1;
        check_disp("blink_sec", 0, 0, 1, 1);
        sel = 1'b0;
        check_disp("blink_min", 0, 0, 1, 1);
        clockBlink_in = 1'b0;
        sel = 1'b1;
        check_disp("no_blink", 0, 0, 1, 0);
        adj = 1'b0; cyc(1);
        pulse(0);
        check_disp("back_to_run", 0, 0, 2, 0);

        // pause inside adjust flips the return mode
        adj = 1'b1; cyc(1);
        press_pause();
        adj = 1'b0; cyc(1);
        pulse(0);
        check_disp("ret_toggled", 0, 0, 2, 0);

        // tick and pause together: tick counts, then paused
        press_pause();
        ev1_with(1'b1, 1'b0);
        check_disp("tick_pause", 0, 0, 3, 0);
        pulse(0);
        check_disp("paused_after", 0, 0, 3, 0);

        // reset wins over a tick, state stays RUN
        press_pause();
        ev1_with(1'b0, 1'b1);
        check_disp("reset_wins", 0, 0, 0, 0);
        pulse(0);
        check_disp("still_run", 0, 0, 1, 0);

        // minutes-tens display (blanked when zero under the leading-zero option)
        do_reset();
        adj = 1'b1; sel = 1'b0; cyc(1);
        pulses(1, 5);
        check_disp("min_05", 0, 5, 0, 0);
        pulses(1, 5);
        check_disp("min_10", 0, 10, 0, 0);
        adj = 1'b0; cyc(1);

        // reset mid-scan
        pulse(2);
        pulse(2);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1; idx = 0;
        chk_an("midscan_an", an, 4'b1110);
        chk_seg("midscan_seg", seg, 7'b1000000);
        cyc(1);
        check_disp("after_midscan", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Consumer end of the master clock divider's outputs.
- Takes the four divided clock levels (1 Hz, 2 Hz, fast ~500 Hz, blink), all generated in the clk domain.
- Turns each rising edge into a one-cycle event and runs an MM:SS stopwatch with pause, clear and adjust modes.
- Drives the 4-digit multiplexed 7-segment display | minT | minO | secT | secO |.

Parameters:
MAX_MIN, 59, highest minute value before wrap to 0 (legal range 1..59).
SEC_MAX, 59, highest second value before wrap to 0 (fixed use; the bench checks only 59).

Ports:
clk  input  1  system clock; the only clock.
rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
clock1Hz_in  input  1  1 Hz level from the divider; each rising edge = one count event.
clock2Hz_in  input  1  2 Hz level; each rising edge = one adjust event.
clockFast_in  input  1  fast level; each rising edge = one digit-scan advance.
clockBlink_in  input  1  blink level; used as a level, not an edge.
btn_pause  input  1  debounced one-cycle pulse; toggles run/pause.
btn_reset  input  1  debounced one-cycle pulse; clears the time to 00:00.
adj  input  1  level; 1 = adjust mode.
sel  input  1  level; adjust target, 0 = minutes, 1 = seconds.
seg  output  7  active-low segments, seg[6]=g … seg[0]=a.
an  output  4  active-low digit enables; an[0]=secO, an[1]=secT, an[2]=minO, an[3]=minT.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). All state and outputs are registered.
- Reset values: time 00:00, state PAUSED, ret_state PAUSED, scan index 0, an=4'b1110, seg=7'b1000000 ("0").
- Edge detect:
  - Each *_in input is registered once; ev = in & ~in_q.
  - An event is asserted the cycle after the input is first sampled high.
  - At reset in_q is loaded with the current input value, so no spurious event is produced.
- Digits (BCD): secO 0-9, secT 0-5, minO 0-9, minT 0-5. A count adds 1 to secO with ripple carry.
  - 09 → 10.
  - 59 s → 00 s plus 1 minute.
  - MAX_MIN:59 → 00:00 (full wrap, no flag).
- States:
  - PAUSED: ev1 ignored.
  - RUN: each ev1 counts +1 s.
  - ADJUST: ev1 ignored. Each ev2 adds 1 to the selected field only. That field wraps at its max (59 → 00 for seconds, MAX_MIN → 00 for minutes) with no carry into the other field.
- Transitions:
  - PAUSED ↔ RUN on btn_pause.
  - adj rising (any state) → ADJUST; the prior state is saved in ret_state.
  - adj=0 while in ADJUST → ret_state.
  - btn_pause in ADJUST toggles ret_state between RUN and PAUSED; the state stays ADJUST.
- Simultaneous events:
  - ev1 with btn_pause in RUN: the tick counts and the state becomes PAUSED; the next-state decision uses the current state.
  - btn_reset with any increment in the same cycle: reset wins, time = 00:00.
  - btn_reset never changes state or ret_state.
  - sel changing mid-ADJUST takes effect on the next ev2.
- Scan:
  - 2-bit index advances 0→1→2→3→0 on each evFast.
  - The an/seg update lands in the same cycle as the index update (registered decode of the next index).
  - an is one-hot low on the current digit.
- Blink: in ADJUST, while clockBlink_in=1, the anodes of the two digits of the selected field are forced high (blanked); the scan index keeps advancing. Outside ADJUST there is no blanking.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- rst_n low mid-scan or mid-adjust: all state returns to the reset values on that edge.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when minT==0 and the scan is on digit 3, an[3] is held 1 (blank). All other behaviour is unchanged, and blink blanking still applies.
- Undefined: minT is always shown, including a leading "0".

Test Plan:
- Reset, then toggle clockFast_in 4 times → an sequence 1101,1011,0111,1110; seg=1000000 each time; ev1 pulses cause no count while PAUSED.
- btn_pause, then 61 clockFast-free ev1 edges → time 01:01; digit 0 shows seg=1111001.
- Preload 59:58 via adjust, set RUN, 2 ev1 → 00:00 (full wrap); with MAX_MIN=9, 09:59 +1 → 00:00.
- adj=1, sel=1, time 00:58, 3 ev2 → 00:01 with minutes unchanged; clockBlink_in=1 at scan index 0/1 → an=1111; adj=0 → returns to the saved state.
- RUN with ev1 and btn_pause in the same cycle → time +1, state PAUSED; btn_reset together with ev1 → 00:00.
- LEADING_ZERO_BLANK_EN defined, time 05:00, scan index 3 → an=1111; time 10:00 → an=0111, seg=1111001.
